// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word over valid/ready
// and shifts it out one bit per enabled clock, with back-to-back reload.
module piso_tx #(
  parameter int WIDTH     = 5,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             en,
  output logic             so,
  output logic             so_valid,
  output logic             so_first,
  output logic             so_last
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [WIDTH-1:0] w_sr_shift;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_accept;

  // Shift toward the output end; the vacated end fills with zero.
  assign w_sr_shift = MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    load_ready  = (r_state == IDLE) || ((r_cnt == '0) && en);
    w_accept    = load_valid && load_ready;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_sr_nxt    = din;
          w_cnt_nxt   = LAST_IDX;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          if (r_cnt != '0) begin
            w_sr_nxt  = w_sr_shift;
            w_cnt_nxt = r_cnt - 1'b1;
          end else if (w_accept) begin
            // Reload on the last-bit edge takes priority over returning to IDLE.
            w_sr_nxt  = din;
            w_cnt_nxt = LAST_IDX;
          end else begin
            w_sr_nxt    = '0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_sr_nxt    = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign so_valid = (r_state == SHIFT);
  assign so       = so_valid && (MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0]);
  assign so_first = so_valid && (r_cnt == LAST_IDX);
  assign so_last  = so_valid && (r_cnt == '0);

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: two instances (5-bit MSB-first, 8-bit LSB-first);
// accepted words are expanded into expected frame bits and popped per enabled edge.
module tb_piso_tx;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } fb_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] din_a;
  logic [7:0] din_b;
  logic       lv  [2];
  logic       en  [2];
  logic       rdy [2];
  logic       so  [2];
  logic       sv  [2];
  logic       sf  [2];
  logic       sl  [2];
  int         en_mode [2];
  int         checks = 0;
  int         errors = 0;
  fb_t        exq [2][$];

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(5), .MSB_FIRST(1'b1)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .din        (din_a),
    .load_valid (lv[0]),
    .load_ready (rdy[0]),
    .en         (en[0]),
    .so         (so[0]),
    .so_valid   (sv[0]),
    .so_first   (sf[0]),
    .so_last    (sl[0])
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .din        (din_b),
    .load_valid (lv[1]),
    .load_ready (rdy[1]),
    .en         (en[1]),
    .so         (so[1]),
    .so_valid   (sv[1]),
    .so_first   (sf[1]),
    .so_last    (sl[1])
  );

  task automatic chk(input string name, input int u, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s unit=%0d t=%0t actual=%b required=%b", name, u, $time, act, exp);
    end
  endtask

  // Expected frame: WIDTH bits in transmit order, first/last flags on the ends.
  task automatic push_frame(input int u, input logic [31:0] d);
    int  w;
    int  idx;
    fb_t e;
    w = (u == 0) ? 5 : 8;
    for (int i = 0; i < w; i++) begin
      idx = (u == 0) ? (w - 1 - i) : i;
      e.b = d[idx];
      e.f = (i == 0);
      e.l = (i == w - 1);
      exq[u].push_back(e);
    end
  endtask

  // Monitor: queue holds exactly the bits from the one on display onward.
  always @(negedge clk) begin : mon
    int  n;
    fb_t h;
    for (int u = 0; u < 2; u++) begin
      n = exq[u].size();
      chk("load_ready", u, rdy[u], (n == 0) || ((n == 1) && (en[u] === 1'b1)));
      chk("so_valid", u, sv[u], n != 0);
      if (n != 0) begin
        h = exq[u][0];
        chk("so", u, so[u], h.b);
        chk("so_first", u, sf[u], h.f);
        chk("so_last", u, sl[u], h.l);
        if (en[u] === 1'b1) void'(exq[u].pop_front());
      end else begin
        chk("so_idle", u, so[u], 1'b0);
        chk("so_first_idle", u, sf[u], 1'b0);
        chk("so_last_idle", u, sl[u], 1'b0);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
        case (en_mode[u])
          0:       en[u] = 1'b1;
          1:       en[u] = ~en[u];
          default: en[u] = ($urandom_range(0, 3) != 0);
        endcase
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int u, input logic [31:0] d);
    int t;
    if (u == 0) din_a = d[4:0];
    else        din_b = d[7:0];
    lv[u] = 1'b1;
    for (t = 0; t < 300; t++) begin
      @(negedge clk);
      #1;
      if (rdy[u]) break;
    end
    if (t == 300) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout unit=%0d actual=no_ready required=ready", u);
      lv[u] = 1'b0;
      return;
    end
    push_frame(u, d);
    @(posedge clk);
    #1;
    lv[u] = 1'b0;
  endtask

  task automatic drain(input int u);
    int t;
    for (t = 0; t < 400; t++) begin
      if (exq[u].size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (t == 400) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout unit=%0d actual=%0d required=0", u, exq[u].size());
    end
    cyc(1);
  endtask

  task automatic rnd(input int u, input int n);
    for (int k = 0; k < n; k++) begin
      cyc($urandom_range(0, 2));
      send(u, $urandom);
    end
  endtask

  task automatic chk_reset_outputs();
    for (int u = 0; u < 2; u++) begin
      chk("rst_so", u, so[u], 1'b0);
      chk("rst_so_valid", u, sv[u], 1'b0);
      chk("rst_so_first", u, sf[u], 1'b0);
      chk("rst_so_last", u, sl[u], 1'b0);
      chk("rst_load_ready", u, rdy[u], 1'b1);
    end
  endtask

  initial begin
    rst        = 1'b0;
    lv         = '{1'b0, 1'b0};
    en         = '{1'b1, 1'b1};
    en_mode    = '{0, 0};
    din_a      = '0;
    din_b      = '0;
    #2;
    chk_reset_outputs();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    cyc(3);

    send(0, 32'b10110);
    drain(0);
    cyc(2);

    send(0, 32'b10110);
    send(0, 32'b01101);
    drain(0);

    en_mode[0] = 1;
    send(0, 32'b11001);
    drain(0);
    en_mode[0] = 0;
    cyc(2);

    // Loads offered while busy must be ignored; then abort mid-frame by reset.
    send(0, 32'b11111);
    cyc(1);
    din_a = '0;
    lv[0] = 1'b1;
    cyc(2);
    lv[0] = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_reset_outputs();
    exq[0].delete();
    exq[1].delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    cyc(2);
    send(0, 32'b10011);
    drain(0);

    send(1, 32'hA5);
    drain(1);

    en_mode = '{2, 2};
    fork
      rnd(0, 40);
      rnd(1, 40);
    join
    en_mode = '{0, 0};
    drain(0);
    drain(1);
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
